// File: rtl/serial_bcd_collector_pkg.sv
// Shared definitions for the serial BCD collector: FSM encoding and nibble constants.
package serial_bcd_collector_pkg;

  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_bcd_collector_nibble_shifter.sv
// LSB-first 4-bit nibble assembler. The last bit is not stored; it is merged
// combinationally so the full nibble is available on the edge that completes it.
module bcd_nibble_shifter
  import serial_bcd_collector_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst,
  input  logic                i_restart,
  input  logic                i_shift,
  input  logic                i_bit,
  output logic [NIBBLE_W-1:0] o_nibble,
  output logic                o_done
);

  logic [1:0] r_count;
  logic [2:0] r_bits;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_count <= 2'd0;
    end else if (i_restart) begin
      r_count <= 2'd1;
    end else if (i_shift) begin
      r_count <= r_count + 2'd1;
    end
  end

  // Bit storage needs no reset: a restart always rewrites bit0 and clears the rest.
  always_ff @(posedge Clk) begin
    if (i_restart) begin
      r_bits <= {2'b00, i_bit};
    end else if (i_shift && (r_count != 2'd3)) begin
      r_bits[r_count] <= i_bit;
    end
  end

  assign o_nibble = {i_bit, r_bits};
  assign o_done   = i_shift && !i_restart && (r_count == 2'd3);

endmodule

// File: rtl/serial_bcd_collector.sv
// Collects serial LSB-first BCD bits into nibbles and NDIGITS-digit words,
// flags bad digits, framing errors and word overrun, with a valid/ack output.
module serial_bcd_collector
  import serial_bcd_collector_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Z_in,
  input  logic                    BitValid,
  input  logic                    DigitStart,
  output logic [NIBBLE_W-1:0]     Digit,
  output logic                    DigitValid,
  output logic                    DigitBad,
  output logic [4*NDIGITS-1:0]    BCD_Word,
  output logic                    WordValid,
  input  logic                    WordAck,
  output logic                    WordBad,
  output logic                    FrameErr,
  output logic                    Overrun
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

  state_t r_state, w_state_nxt;

  logic                  w_restart;
  logic                  w_shift;
  logic                  w_frame_err;
  logic                  w_done;
  logic                  w_nib_bad;
  logic                  w_word_done;
  logic [NIBBLE_W-1:0]   w_nibble;
  logic [4*NDIGITS-1:0]  w_full;

  logic [IDX_W-1:0]      r_idx;
  logic [4*NDIGITS-1:0]  r_asm;
  logic                  r_acc_bad;
  logic [NIBBLE_W-1:0]   r_digit;
  logic                  r_digit_valid;
  logic                  r_digit_bad;
  logic [4*NDIGITS-1:0]  r_word;
  logic                  r_word_valid;
  logic                  r_word_bad;
  logic                  r_frame_err;
  logic                  r_overrun;

  bcd_nibble_shifter u_shifter (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_restart (w_restart),
    .i_shift   (w_shift),
    .i_bit     (Z_in),
    .o_nibble  (w_nibble),
    .o_done    (w_done)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_shift     = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (BitValid) begin
          if (DigitStart) begin
            w_restart   = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_frame_err = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (BitValid) begin
          if (DigitStart) begin
            w_frame_err = 1'b1;
            w_restart   = 1'b1;
          end else begin
            w_shift = 1'b1;
            if (w_done) w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Completed word image: stored slots with the finishing nibble dropped into slot r_idx.
  always_comb begin
    w_full                 = r_asm;
    w_full[4*r_idx +: 4]   = w_nibble;
  end

  assign w_nib_bad   = (w_nibble > BCD_MAX);
  assign w_word_done = w_done && (r_idx == LAST_IDX);

  always_ff @(posedge Clk) begin
    if (w_done) r_asm <= w_full;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_idx         <= '0;
      r_acc_bad     <= 1'b0;
      r_digit       <= '0;
      r_digit_valid <= 1'b0;
      r_digit_bad   <= 1'b0;
      r_word        <= '0;
      r_word_valid  <= 1'b0;
      r_word_bad    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_digit_valid <= w_done;
      r_frame_err   <= w_frame_err;
      if (r_word_valid && WordAck) r_word_valid <= 1'b0;
      if (w_done) begin
        r_digit     <= w_nibble;
        r_digit_bad <= w_nib_bad;
        if (w_word_done) begin
          r_idx     <= '0;
          r_acc_bad <= 1'b0;
          // A pending word is only replaced if it is acked on this same edge.
          if (!r_word_valid || WordAck) begin
            r_word       <= w_full;
            r_word_bad   <= r_acc_bad || w_nib_bad;
            r_word_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end else begin
          r_idx     <= r_idx + IDX_W'(1);
          r_acc_bad <= r_acc_bad || w_nib_bad;
        end
      end
    end
  end

  assign Digit      = r_digit;
  assign DigitValid = r_digit_valid;
  assign DigitBad   = r_digit_bad;
  assign BCD_Word   = r_word;
  assign WordValid  = r_word_valid;
  assign WordBad    = r_word_bad;
  assign FrameErr   = r_frame_err;
  assign Overrun    = r_overrun;

endmodule

// File: tb/tb_serial_bcd_collector.sv
// Directed bench for serial_bcd_collector with digit/word scoreboards.
module tb_serial_bcd_collector;

  localparam int ND = 4;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Z_in = 1'b0;
  logic          BitValid = 1'b0;
  logic          DigitStart = 1'b0;
  logic [3:0]    Digit;
  logic          DigitValid;
  logic          DigitBad;
  logic [4*ND-1:0] BCD_Word;
  logic          WordValid;
  logic          WordAck = 1'b0;
  logic          WordBad;
  logic          FrameErr;
  logic          Overrun;

  int tests = 0;
  int fails = 0;
  int fe_seen = 0;
  int fe_base = 0;
  logic prev_wv = 1'b0;

  logic [4:0]      dig_q[$];
  logic [4*ND:0]   word_q[$];

  serial_bcd_collector #(.NDIGITS(ND)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Z_in       (Z_in),
    .BitValid   (BitValid),
    .DigitStart (DigitStart),
    .Digit      (Digit),
    .DigitValid (DigitValid),
    .DigitBad   (DigitBad),
    .BCD_Word   (BCD_Word),
    .WordValid  (WordValid),
    .WordAck    (WordAck),
    .WordBad    (WordBad),
    .FrameErr   (FrameErr),
    .Overrun    (Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [4:0]    d;
    logic [4*ND:0] w;
    @(posedge Clk);
    #1;
    if (DigitValid) begin
      if (dig_q.size() == 0) chk("digit_unexpected", {27'd0, DigitBad, Digit}, 32'hFFFF);
      else begin
        d = dig_q.pop_front();
        chk("digit_value", {28'd0, Digit}, {28'd0, d[3:0]});
        chk("digit_bad", {31'd0, DigitBad}, {31'd0, d[4]});
      end
    end
    if (WordValid && !prev_wv) begin
      if (word_q.size() == 0) chk("word_unexpected", {15'd0, WordBad, BCD_Word}, 32'hFFFFFFFF);
      else begin
        w = word_q.pop_front();
        chk("word_value", {16'd0, BCD_Word}, {16'd0, w[4*ND-1:0]});
        chk("word_bad", {31'd0, WordBad}, {31'd0, w[4*ND]});
      end
    end
    if (FrameErr) fe_seen++;
    prev_wv = WordValid;
  endtask

  task automatic send_bit(input logic z, input logic start);
    BitValid = 1'b1; Z_in = z; DigitStart = start;
    tick();
    BitValid = 1'b0; Z_in = 1'b0; DigitStart = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] v, input int gap, input logic ack_last);
    dig_q.push_back({(v > 4'd9), v});
    for (int b = 0; b < 4; b++) begin
      BitValid = 1'b1; Z_in = v[b]; DigitStart = (b == 0);
      WordAck = ack_last && (b == 3);
      tick();
      BitValid = 1'b0; Z_in = 1'b0; DigitStart = 1'b0; WordAck = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic ack_word();
    WordAck = 1'b1;
    tick();
    WordAck = 1'b0;
  endtask

  initial begin
    // Reset and idle
    Rst = 1'b1; tick(); tick();
    Rst = 1'b0; tick(); tick();
    chk("rst_digit", {28'd0, Digit}, 32'd0);
    chk("rst_dvalid", {31'd0, DigitValid}, 32'd0);
    chk("rst_dbad", {31'd0, DigitBad}, 32'd0);
    chk("rst_word", {16'd0, BCD_Word}, 32'd0);
    chk("rst_wvalid", {31'd0, WordValid}, 32'd0);
    chk("rst_wbad", {31'd0, WordBad}, 32'd0);
    chk("rst_frameerr", {31'd0, FrameErr}, 32'd0);
    chk("rst_overrun", {31'd0, Overrun}, 32'd0);

    // Word A: 5,0,9,3
    word_q.push_back({1'b0, 16'h3905});
    send_digit(4'd5, 0, 1'b0);
    send_digit(4'd0, 0, 1'b0);
    send_digit(4'd9, 0, 1'b0);
    send_digit(4'd3, 0, 1'b0);
    chk("a_wvalid", {31'd0, WordValid}, 32'd1);
    tick();
    chk("a_wvalid_held", {31'd0, WordValid}, 32'd1);
    ack_word();
    chk("a_ack_clears", {31'd0, WordValid}, 32'd0);
    chk("a_word_holds", {16'd0, BCD_Word}, 32'h3905);
    ack_word();
    chk("ack_idle_ignored", {31'd0, WordValid}, 32'd0);

    // Word B contains a non-BCD nibble (10)
    word_q.push_back({1'b1, 16'h72A1});
    send_digit(4'd1, 0, 1'b0);
    send_digit(4'd10, 0, 1'b0);
    send_digit(4'd2, 0, 1'b0);
    send_digit(4'd7, 0, 1'b0);
    ack_word();

    // Framing: restart after 2 bits, stray bit in IDLE, start without BitValid
    fe_base = fe_seen;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    word_q.push_back({1'b0, 16'h1846});
    send_digit(4'd6, 0, 1'b0);
    send_bit(1'b1, 1'b0);
    DigitStart = 1'b1; tick(); DigitStart = 1'b0;
    tick();
    chk("frame_err_count", fe_seen - fe_base, 32'd2);
    chk("frame_no_digit", dig_q.size(), 32'd0);
    send_digit(4'd4, 0, 1'b0);
    send_digit(4'd8, 0, 1'b0);
    send_digit(4'd1, 0, 1'b0);

    // Word E completes with WordAck on the same edge while C is pending
    send_digit(4'd3, 0, 1'b0);
    send_digit(4'd1, 0, 1'b0);
    send_digit(4'd4, 0, 1'b0);
    send_digit(4'd1, 0, 1'b1);
    chk("e_word_loaded", {16'd0, BCD_Word}, 32'h1413);
    chk("e_wvalid_stays", {31'd0, WordValid}, 32'd1);
    chk("e_no_overrun", {31'd0, Overrun}, 32'd0);

    // Word D without ack: dropped, Overrun set
    send_digit(4'd2, 0, 1'b0);
    send_digit(4'd2, 0, 1'b0);
    send_digit(4'd2, 0, 1'b0);
    send_digit(4'd2, 0, 1'b0);
    chk("d_overrun", {31'd0, Overrun}, 32'd1);
    chk("d_word_kept", {16'd0, BCD_Word}, 32'h1413);
    chk("d_wvalid", {31'd0, WordValid}, 32'd1);
    tick();
    chk("overrun_sticky", {31'd0, Overrun}, 32'd1);
    ack_word();
    chk("d_ack_clears", {31'd0, WordValid}, 32'd0);

    // Reset mid-word discards partial data
    send_digit(4'd9, 0, 1'b0);
    send_digit(4'd8, 0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    Rst = 1'b1; tick(); Rst = 1'b0;
    chk("mid_rst_overrun", {31'd0, Overrun}, 32'd0);
    chk("mid_rst_word", {16'd0, BCD_Word}, 32'd0);
    chk("mid_rst_wvalid", {31'd0, WordValid}, 32'd0);

    // Next word with 3-cycle gaps between bits assembles from slot 0
    word_q.push_back({1'b0, 16'h1357});
    send_digit(4'd7, 3, 1'b0);
    send_digit(4'd5, 3, 1'b0);
    send_digit(4'd3, 3, 1'b0);
    send_digit(4'd1, 3, 1'b0);
    chk("gap_wvalid", {31'd0, WordValid}, 32'd1);
    chk("gap_word", {16'd0, BCD_Word}, 32'h1357);
    ack_word();
    tick();

    chk("dig_q_drained", dig_q.size(), 32'd0);
    chk("word_q_drained", word_q.size(), 32'd0);
    chk("final_overrun", {31'd0, Overrun}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
